// File: rtl/seq_detector_pkg.sv
// ---------------------------------------------------------------------------
// seq_detector_pkg
//   Shared types and helpers for the serial pattern detector.
//   - state_t     : control FSM encoding (IDLE / FILL / HUNT)
//   - calc_len_w  : width needed to hold a pattern length 0..max_len
//   - sat_inc     : increment that holds at a given limit
//   Optional feature macro used by the detector: SEQDET_MASK_EN.
// ---------------------------------------------------------------------------
package seq_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // disarmed, no valid pattern
    ST_FILL = 2'd1,  // fewer than len bits seen since load or last match
    ST_HUNT = 2'd2   // history is full enough to compare every bit
  } state_t;

  // Width of a field able to hold every length from 0 up to max_len.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Saturating increment. Operands are 32 bits wide, so callers narrower
  // than 32 bits cast in and out; counters wider than 32 bits are not
  // supported by this helper.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage : seq_detector_pkg

// File: rtl/seq_match_counter.sv
// ---------------------------------------------------------------------------
// seq_match_counter
//   Saturating event counter. Clear has priority over increment, so a clear
//   arriving in the same cycle as an event leaves the count at zero.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   synchronous active-low reset
//     inc    in   count one event (holds at all-ones)
//     clr    in   force count to zero
//     cnt    out  CNT_W current count
// ---------------------------------------------------------------------------
module seq_match_counter
  import seq_detector_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  logic [CNT_W-1:0] r_cnt;

  // NOTE: the reset is synchronous, so it lives inside the clocked branch and
  // is not in the sensitivity list; sequential state always uses <= so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_MAX));
    end
  end

  assign cnt = r_cnt;

endmodule : seq_match_counter

// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
//   Runtime-programmable serial bit-pattern detector. Every qualified bit is
//   shifted into a history register; when the newest len bits equal the
//   loaded pattern a registered one-cycle pulse is raised on z and a
//   saturating match counter advances. Overlapping or non-overlapping
//   detection is chosen at load time.
//   Optional feature: define SEQDET_MASK_EN to add cfg_mask, a per-position
//   don't-care mask latched together with the pattern.
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   synchronous active-low reset
//     in_valid     in   in_bit is sampled this cycle
//     in_bit       in   serial data bit
//     cfg_load     in   latch pattern/len/overlap(/mask), clear history
//     cfg_pattern  in   MAX_LEN pattern, bit len-1 received first
//     cfg_len      in   LEN_W pattern length (clamped to MAX_LEN, 0 disarms)
//     cfg_overlap  in   1 = overlapping detection
//     cfg_mask     in   MAX_LEN don't-care bits (SEQDET_MASK_EN only)
//     cnt_clr      in   clear the match counter (wins over a match)
//     z            out  one-cycle match pulse
//     match_cnt    out  CNT_W saturating match count
//     armed        out  a pattern with nonzero length is loaded
// ---------------------------------------------------------------------------
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQDET_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  // Configuration registers
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
`ifdef SEQDET_MASK_EN
  logic [MAX_LEN-1:0] r_mask;
`endif

  // Datapath and control registers
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_z;
  state_t             r_state;

  // Combinational helpers
  state_t             w_state_next;
  logic [LEN_W-1:0]   w_len_clamped;
  logic [MAX_LEN-1:0] w_hist_shift;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_fill_done;
  logic [MAX_LEN-1:0] w_len_mask;
  logic [MAX_LEN-1:0] w_cmp_mask;
  logic               w_hit;
  logic               w_match;

  // Over-long lengths are clamped so a mis-programmed length still arms.
  assign w_len_clamped = (32'(cfg_len) > 32'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

  // History as it will look after this cycle's bit. The top bit falls off;
  // the concatenation keeps every stored bit referenced before truncation.
  assign w_hist_shift = MAX_LEN'({r_hist, in_bit});
  assign w_fill_next  = LEN_W'(sat_inc(32'(r_fill), 32'(MAX_LEN)));
  assign w_fill_done  = (w_fill_next >= r_len);

  // Select only the low len positions of the history for comparison.
  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < r_len) begin
        w_len_mask[i] = 1'b1;
      end
    end
  end

`ifdef SEQDET_MASK_EN
  assign w_cmp_mask = w_len_mask & ~r_mask;
`else
  assign w_cmp_mask = w_len_mask;
`endif

  assign w_hit = (((w_hist_shift ^ r_pat) & w_cmp_mask) == '0);

  // A load in the same cycle discards the bit, so it can never match. The
  // state guard matters because a zero-length config compares nothing and
  // would otherwise hit on every bit.
  assign w_match = in_valid && !cfg_load && (r_state != ST_IDLE) &&
                   w_hit && w_fill_done;

  // -------------------------------------------------------------------------
  // Control FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (cfg_load) begin
      w_state_next = (w_len_clamped == '0) ? ST_IDLE : ST_FILL;
    end else if (in_valid) begin
      case (r_state)
        ST_IDLE: w_state_next = ST_IDLE;
        ST_FILL: begin
          if (w_match) begin
            w_state_next = r_overlap ? ST_HUNT : ST_FILL;
          end else if (w_fill_done) begin
            w_state_next = ST_HUNT;
          end
        end
        ST_HUNT: begin
          if (w_match && !r_overlap) begin
            w_state_next = ST_FILL;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Configuration, history, fill counter and match pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
`ifdef SEQDET_MASK_EN
      r_mask    <= '0;
`endif
      r_hist    <= '0;
      r_fill    <= '0;
      r_z       <= 1'b0;
    end else begin
      // w_match is already low on idle and load cycles, so the pulse
      // self-clears after one cycle.
      r_z <= w_match;
      if (cfg_load) begin
        r_pat     <= cfg_pattern;
        r_len     <= w_len_clamped;
        r_overlap <= cfg_overlap;
`ifdef SEQDET_MASK_EN
        r_mask    <= cfg_mask;
`endif
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (in_valid) begin
        if (w_match && !r_overlap) begin
          // Non-overlapping: the matched bits may not start the next match.
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_hist_shift;
          r_fill <= w_fill_next;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Match counter (updates on the same edge as z)
  // -------------------------------------------------------------------------
  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_match),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );

  assign z     = r_z;
  assign armed = (r_state != ST_IDLE);

endmodule : seq_detector

// File: tb/tb_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_detector
//   Directed bench for seq_detector. Two instances share every input: u_dut
//   uses the default parameters, u_dut_sat uses CNT_W=2 for counter
//   saturation. Inputs change on the falling edge and outputs are sampled on
//   the following falling edge, i.e. one rising edge after the stimulus.
//   Define SEQDET_MASK_EN for both RTL and bench to exercise the mask.
// ---------------------------------------------------------------------------
module tb_seq_detector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
`ifdef SEQDET_MASK_EN
  logic [7:0]  cfg_mask;
`endif
  logic        cnt_clr;

  logic        z;
  logic [15:0] match_cnt;
  logic        armed;
  logic        z_sat;
  logic [1:0]  match_cnt_sat;
  logic        armed_sat;

  int total = 0;
  int bad   = 0;

  seq_detector #(
    .MAX_LEN (8),
    .CNT_W   (16)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
`ifdef SEQDET_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .cnt_clr     (cnt_clr),
    .z           (z),
    .match_cnt   (match_cnt),
    .armed       (armed)
  );

  seq_detector #(
    .MAX_LEN (8),
    .CNT_W   (2)
  ) u_dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
`ifdef SEQDET_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .cnt_clr     (cnt_clr),
    .z           (z_sat),
    .match_cnt   (match_cnt_sat),
    .armed       (armed_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- stimulus helpers (no checking) -------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input logic ov);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    @(negedge clk);
    cfg_load    = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  // ---- scenarios -----------------------------------------------------------
  task automatic test_reset();
    logic [3:0] bits;
    bits = 4'b0000;
    total++;
    if (z !== 1'b0 || armed !== 1'b0 || match_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: z=%b armed=%b cnt=%0d want 0 0 0", z, armed, match_cnt);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 3; i >= 0; i--) begin
      drive_bit(bits[i]);
      total++;
      if (z !== 1'b0) begin
        bad++;
        $display("FAIL reset_stream bit%0d: z=%b want 0", 3 - i, z);
      end
    end
    total++;
    if (armed !== 1'b0 || match_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_after_stream: armed=%b cnt=%0d want 0 0", armed, match_cnt);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] bits;
    logic [6:0] exp_z;
    bits  = 7'b1011011;
    exp_z = 7'b0001000;
    clear_cnt();
    load_cfg(8'b0000_1011, 4'd4, 1'b0);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("FAIL nonoverlap_armed: armed=%b want 1", armed);
    end
    for (int i = 6; i >= 0; i--) begin
      drive_bit(bits[i]);
      total++;
      if (z !== exp_z[i]) begin
        bad++;
        $display("FAIL nonoverlap_1011 bit%0d: z=%b want %b", 6 - i, z, exp_z[i]);
      end
    end
    total++;
    if (match_cnt !== 16'd1) begin
      bad++;
      $display("FAIL nonoverlap_cnt: cnt=%0d want 1", match_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] bits;
    logic [4:0] exp_ov;
    logic [4:0] exp_no;
    bits   = 5'b10101;
    exp_ov = 5'b00101;
    exp_no = 5'b00100;
    clear_cnt();
    load_cfg(8'b0000_0101, 4'd3, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      drive_bit(bits[i]);
      total++;
      if (z !== exp_ov[i]) begin
        bad++;
        $display("FAIL overlap_101 bit%0d: z=%b want %b", 4 - i, z, exp_ov[i]);
      end
    end
    total++;
    if (match_cnt !== 16'd2) begin
      bad++;
      $display("FAIL overlap_cnt: cnt=%0d want 2", match_cnt);
    end
    clear_cnt();
    load_cfg(8'b0000_0101, 4'd3, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      drive_bit(bits[i]);
      total++;
      if (z !== exp_no[i]) begin
        bad++;
        $display("FAIL nonoverlap_101 bit%0d: z=%b want %b", 4 - i, z, exp_no[i]);
      end
    end
    total++;
    if (match_cnt !== 16'd1) begin
      bad++;
      $display("FAIL nonoverlap_101_cnt: cnt=%0d want 1", match_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_z;
    exp_z = 4'b0111;
    clear_cnt();
    load_cfg(8'b0000_0011, 4'd2, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      drive_bit(1'b1);
      total++;
      if (z !== exp_z[i]) begin
        bad++;
        $display("FAIL back_to_back bit%0d: z=%b want %b", 3 - i, z, exp_z[i]);
      end
    end
    // Idle cycles: pulse drops and history holds across the gap.
    tick();
    tick();
    total++;
    if (z !== 1'b0 || match_cnt !== 16'd3) begin
      bad++;
      $display("FAIL idle_hold: z=%b cnt=%0d want 0 3", z, match_cnt);
    end
    drive_bit(1'b1);
    total++;
    if (z !== 1'b1 || match_cnt !== 16'd4) begin
      bad++;
      $display("FAIL after_gap: z=%b cnt=%0d want 1 4", z, match_cnt);
    end
  endtask

  task automatic test_load_collision();
    logic [2:0] bits;
    bits = 3'b111;
    clear_cnt();
    load_cfg(8'b0000_0011, 4'd2, 1'b1);
    drive_bit(1'b1);
    // Reload in the same cycle as a valid bit: the bit must be dropped.
    cfg_load = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    cfg_load = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL collision_load_cycle: z=%b want 0", z);
    end
    drive_bit(1'b1);
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL collision_straddle: z=%b want 0", z);
    end
    drive_bit(1'b1);
    total++;
    if (z !== 1'b1) begin
      bad++;
      $display("FAIL collision_fresh_match: z=%b want 1", z);
    end
    load_cfg(8'b0000_0011, 4'd0, 1'b1);
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL len0_armed: armed=%b want 0", armed);
    end
    for (int i = 2; i >= 0; i--) begin
      drive_bit(bits[i]);
      total++;
      if (z !== 1'b0) begin
        bad++;
        $display("FAIL len0_stream bit%0d: z=%b want 0", 2 - i, z);
      end
    end
    total++;
    if (match_cnt !== 16'd1) begin
      bad++;
      $display("FAIL collision_cnt: cnt=%0d want 1", match_cnt);
    end
  endtask

  task automatic test_len_clamp();
    logic [7:0] bits;
    logic [7:0] exp_z;
    bits  = 8'b1010_0101;
    exp_z = 8'b0000_0001;
    clear_cnt();
    load_cfg(8'hA5, 4'd15, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(bits[i]);
      total++;
      if (z !== exp_z[i]) begin
        bad++;
        $display("FAIL len_clamp bit%0d: z=%b want %b", 7 - i, z, exp_z[i]);
      end
    end
    total++;
    if (match_cnt !== 16'd1) begin
      bad++;
      $display("FAIL len_clamp_cnt: cnt=%0d want 1", match_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0] exp_z;
    exp_z = 3'b001;
    load_cfg(8'b0000_0111, 4'd3, 1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (armed !== 1'b0 || match_cnt !== 16'd0 || z !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: armed=%b cnt=%0d z=%b want 0 0 0", armed, match_cnt, z);
    end
    drive_bit(1'b1);
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_match: z=%b want 0", z);
    end
    load_cfg(8'b0000_0111, 4'd3, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      drive_bit(1'b1);
      total++;
      if (z !== exp_z[i]) begin
        bad++;
        $display("FAIL midreset_reload bit%0d: z=%b want %b", 2 - i, z, exp_z[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load_cfg(8'b0000_0001, 4'd1, 1'b1);
    clear_cnt();
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b1);
      total++;
      if (match_cnt_sat !== exp_cnt[i]) begin
        bad++;
        $display("FAIL sat_cnt match%0d: cnt=%0d want %0d", i + 1, match_cnt_sat, exp_cnt[i]);
      end
    end
    total++;
    if (match_cnt !== 16'd5 || armed_sat !== 1'b1) begin
      bad++;
      $display("FAIL sat_wide_cnt: cnt=%0d armed=%b want 5 1", match_cnt, armed_sat);
    end
    // Clear together with a match: the pulse still fires, the count is zero.
    cnt_clr  = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    total++;
    if (z_sat !== 1'b1 || match_cnt_sat !== 2'd0 || match_cnt !== 16'd0) begin
      bad++;
      $display("FAIL clr_on_match: z=%b cnt_sat=%0d cnt=%0d want 1 0 0", z_sat, match_cnt_sat, match_cnt);
    end
  endtask

`ifdef SEQDET_MASK_EN
  task automatic test_mask();
    logic [7:0] bits;
    logic [7:0] exp_z;
    bits  = 8'b1111_1001;
    exp_z = 8'b0001_0001;
    cfg_mask = 8'b0000_0110;
    clear_cnt();
    load_cfg(8'b0000_1001, 4'd4, 1'b0);
    cfg_mask = 8'b0000_0000;
    for (int i = 7; i >= 0; i--) begin
      drive_bit(bits[i]);
      total++;
      if (z !== exp_z[i]) begin
        bad++;
        $display("FAIL mask bit%0d: z=%b want %b", 7 - i, z, exp_z[i]);
      end
    end
    total++;
    if (match_cnt !== 16'd2) begin
      bad++;
      $display("FAIL mask_cnt: cnt=%0d want 2", match_cnt);
    end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
`ifdef SEQDET_MASK_EN
    cfg_mask    = 8'h00;
`endif
    cnt_clr     = 1'b0;
    repeat (3) tick();

    test_reset();
    test_nonoverlap();
    test_overlap();
    test_back_to_back();
    test_load_collision();
    test_len_clamp();
    test_reset_midstream();
    test_saturation();
`ifdef SEQDET_MASK_EN
    test_mask();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_detector
